// File: rtl/corrupt_scheduler.sv
// Frame-aligned corruption scheduler: tracks row/column from the valid/FAS byte stream
// and gates the line corruptor per whole frame. Optional statistics ports: CORRUPT_SCHED_STATS_EN.
module corrupt_scheduler #(
    parameter int P_ROWS = 4,
    parameter int P_COLS = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_frame_data_valid,
    input  logic        i_frame_data_fas,
    input  logic        i_sw_enable,
    input  logic [1:0]  i_sw_mode,
    input  logic [7:0]  i_burst_len,
    input  logic [7:0]  i_gap_len,
    input  logic [7:0]  i_seed,
    output logic [1:0]  o_row_cnt,
    output logic [10:0] o_col_cnt,
    output logic        o_corrupt_en,
    output logic [7:0]  o_corrupt_seed,
    output logic        o_locked
`ifdef CORRUPT_SCHED_STATS_EN
    ,
    output logic [15:0] o_frames_corrupted,
    output logic [7:0]  o_lock_losses
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP, S_DONE} sched_e;
    typedef enum logic {L_HUNT, L_LOCKED} lock_e;

    localparam logic [1:0]  LAST_ROW = 2'(P_ROWS - 1);
    localparam logic [10:0] LAST_COL = 11'(P_COLS - 1);

    logic [1:0]  row_q, row_d, cur_row;
    logic [10:0] col_q, col_d, cur_col;
    lock_e       lock_q, lock_d;
    sched_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        en_q;
    logic [7:0]  seed_q;
    logic        byte_fas, pos_zero, lock_loss, fs, start_ok;

    assign byte_fas  = i_frame_data_valid & i_frame_data_fas;
    assign pos_zero  = (row_q == 2'd0) && (col_q == 11'd0);
    assign cur_row   = byte_fas ? 2'd0 : row_q;
    assign cur_col   = byte_fas ? 11'd0 : col_q;
    assign lock_loss = (lock_q == L_LOCKED) & i_frame_data_valid & ~i_frame_data_fas & pos_zero;
    // A frame start is a FAS either at the expected position or while still hunting.
    assign fs        = byte_fas & ((lock_q == L_HUNT) | pos_zero);
    assign start_ok  = i_sw_enable & (i_sw_mode != 2'd0)
                     & ((i_sw_mode == 2'd1) | (i_burst_len != 8'd0));

    assign o_row_cnt      = cur_row;
    assign o_col_cnt      = cur_col;
    assign o_corrupt_en   = en_q;
    assign o_corrupt_seed = seed_q;
    assign o_locked       = (lock_q == L_LOCKED);

    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (i_frame_data_valid) begin
            if (cur_col == LAST_COL) begin
                col_d = 11'd0;
                row_d = (cur_row == LAST_ROW) ? 2'd0 : cur_row + 2'd1;
            end else begin
                col_d = cur_col + 11'd1;
                row_d = cur_row;
            end
        end
    end

    always_comb begin
        lock_d = lock_q;
        if (byte_fas)       lock_d = L_LOCKED;
        else if (lock_loss) lock_d = L_HUNT;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (fs && start_ok) begin
                    state_d = S_BURST;
                    cnt_d   = 8'd1;
                end
            end
            S_BURST: begin
                if (!i_sw_enable || lock_loss) begin
                    state_d = S_IDLE;
                end else if (fs) begin
                    if (i_sw_mode == 2'd0) begin
                        state_d = S_IDLE;
                    end else if (i_sw_mode == 2'd1) begin
                        state_d = S_BURST;
                    end else if (cnt_q == i_burst_len) begin
                        if (i_sw_mode == 2'd3) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = (i_gap_len == 8'd0) ? S_BURST : S_GAP;
                            cnt_d   = 8'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_GAP: begin
                if (!i_sw_enable || lock_loss) begin
                    state_d = S_IDLE;
                end else if (fs) begin
                    if (i_sw_mode == 2'd0) begin
                        state_d = S_IDLE;
                    end else if (cnt_q == i_gap_len) begin
                        state_d = S_BURST;
                        cnt_d   = 8'd1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_DONE: begin
                if (!i_sw_enable) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            row_q   <= 2'd0;
            col_q   <= 11'd0;
            lock_q  <= L_HUNT;
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            en_q    <= 1'b0;
            seed_q  <= 8'h01;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            lock_q  <= lock_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= (state_d == S_BURST);
            // An all-zero seed would lock the LFSR, so it is promoted to 1.
            if (state_q == S_IDLE) seed_q <= (i_seed == 8'h00) ? 8'h01 : i_seed;
        end
    end

`ifdef CORRUPT_SCHED_STATS_EN
    logic [15:0] frames_q;
    logic [7:0]  losses_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frames_q <= 16'd0;
            losses_q <= 8'd0;
        end else begin
            if (fs && (state_d == S_BURST) && (frames_q != 16'hFFFF)) frames_q <= frames_q + 16'd1;
            if (lock_loss && (losses_q != 8'hFF)) losses_q <= losses_q + 8'd1;
        end
    end

    assign o_frames_corrupted = frames_q;
    assign o_lock_losses      = losses_q;
`endif

endmodule

// File: tb/tb_corrupt_scheduler.sv
// Self-checking bench for corrupt_scheduler: directed scenarios plus a random stream,
// compared against a frame-level reference model (linear byte index, frame count per schedule).
module tb_corrupt_scheduler;

    localparam int ROWS  = 3;
    localparam int COLS  = 20;
    localparam int FRAME = ROWS * COLS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        fas = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  burst = 8'd0;
    logic [7:0]  gap = 8'd0;
    logic [7:0]  seed = 8'd0;
    logic [1:0]  row_o;
    logic [10:0] col_o;
    logic        corrupt_en_o;
    logic [7:0]  seed_o;
    logic        locked_o;
`ifdef CORRUPT_SCHED_STATS_EN
    logic [15:0] frames_o;
    logic [7:0]  losses_o;
`endif

    always #5 clk = ~clk;

    corrupt_scheduler #(.P_ROWS(ROWS), .P_COLS(COLS)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_frame_data_valid (valid),
        .i_frame_data_fas   (fas),
        .i_sw_enable        (en),
        .i_sw_mode          (mode),
        .i_burst_len        (burst),
        .i_gap_len          (gap),
        .i_seed             (seed),
        .o_row_cnt          (row_o),
        .o_col_cnt          (col_o),
        .o_corrupt_en       (corrupt_en_o),
        .o_corrupt_seed     (seed_o),
        .o_locked           (locked_o)
`ifdef CORRUPT_SCHED_STATS_EN
        ,
        .o_frames_corrupted (frames_o),
        .o_lock_losses      (losses_o)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: position as a linear byte index, schedule as frames since start.
    bit         m_locked, m_active, m_done;
    int         m_p, m_k, m_mode, m_b, m_g, m_frames, m_losses;
    logic [7:0] m_seed;

    function automatic bit m_corrupt();
        return m_active && ((m_mode == 1)
                         || (m_mode == 2 && (m_k % (m_b + m_g)) < m_b)
                         || (m_mode == 3 && m_k < m_b));
    endfunction

    task automatic model_reset();
        m_locked = 0; m_active = 0; m_done = 0;
        m_p = 0; m_k = 0; m_mode = 0; m_b = 0; m_g = 0;
        m_frames = 0; m_losses = 0; m_seed = 8'h01;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; applies one cycle of stream input and checks both phases.
    task automatic byte_cycle(input bit v, input bit f);
        int cur;
        bit fs_now, loss_now;
        valid = v;
        fas   = f;
        seed  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        #1;
        cur = (v && f) ? 0 : m_p;
        check("row", row_o, cur / COLS);
        check("col", col_o, cur % COLS);
        loss_now = m_locked && v && !f && (m_p == 0);
        fs_now   = v && f && (!m_locked || m_p == 0);
        if (!m_active && !m_done) m_seed = (seed == 8'h00) ? 8'h01 : seed;
        if (m_done) begin
            if (!en) m_done = 0;
        end else if (m_active) begin
            if (!en || loss_now) m_active = 0;
            else if (fs_now) begin
                if (mode == 2'd0) m_active = 0;
                else begin
                    m_k++;
                    if (m_mode == 3 && m_k >= m_b) begin
                        m_active = 0;
                        m_done   = 1;
                    end
                end
            end
        end else if (fs_now && en && mode != 2'd0 && (mode == 2'd1 || burst != 8'd0)) begin
            m_active = 1; m_k = 0; m_mode = int'(mode); m_b = int'(burst); m_g = int'(gap);
        end
        if (fs_now && m_corrupt() && m_frames < 65535) m_frames++;
        if (loss_now && m_losses < 255) m_losses++;
        if (v && f) m_locked = 1;
        else if (loss_now) m_locked = 0;
        if (v) m_p = (cur + 1) % FRAME;
        @(posedge clk);
        #1;
        check("locked", locked_o, m_locked);
        check("corrupt_en", corrupt_en_o, m_corrupt());
        check("seed", seed_o, m_seed);
`ifdef CORRUPT_SCHED_STATS_EN
        check("frames_corrupted", frames_o, m_frames);
        check("lock_losses", losses_o, m_losses);
`endif
    endtask

    task automatic do_reset();
        valid = 1'b1;
        fas   = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_locked", locked_o, 0);
        check("rst_en", corrupt_en_o, 0);
        check("rst_seed", seed_o, 8'h01);
        check("rst_row", row_o, 0);
        check("rst_col", col_o, 0);
`ifdef CORRUPT_SCHED_STATS_EN
        check("rst_frames", frames_o, 0);
        check("rst_losses", losses_o, 0);
`endif
        valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_cfg(input bit e, input logic [1:0] md, input logic [7:0] b, input logic [7:0] g);
        en = 1'b0;
        byte_cycle(0, 0);
        mode  = md;
        burst = b;
        gap   = g;
        en    = e;
    endtask

    task automatic send_frame(input bit with_fas, output bit en_mid);
        en_mid = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            while ($urandom_range(0, 3) == 0) byte_cycle(0, 0);
            byte_cycle(1, (i == 0) && with_fas);
            if (i == FRAME / 2) en_mid = corrupt_en_o;
        end
    endtask

    task automatic finish_frame();
        for (int i = 0; i < FRAME && m_p != 0; i++) byte_cycle(1, 0);
    endtask

    initial begin
        bit em;
        bit pat4 [10] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
        bit pat5 [5]  = '{1, 1, 1, 0, 0};
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // No FAS at all: free-running position, never locks, never enables.
        en = 1'b1; mode = 2'd1;
        for (int i = 0; i < 150; i++) byte_cycle(1, 0);
        check("t1_locked", locked_o, 0);
        check("t1_en", corrupt_en_o, 0);

        // Aligned frames with corruption disabled.
        set_cfg(0, 2'd1, 8'd0, 8'd0);
        for (int f = 0; f < 3; f++) send_frame(1, em);
        check("t2_locked", locked_o, 1);

        // Continuous mode, enable drop mid-frame, then mode 0 taking effect at the next FS.
        set_cfg(1, 2'd1, 8'd0, 8'd0);
        for (int f = 0; f < 2; f++) begin
            send_frame(1, em);
            check("t3_en_mid", em, 1);
        end
        for (int i = 0; i < 10; i++) byte_cycle(1, (i == 0));
        check("t3_en_on", corrupt_en_o, 1);
        en = 1'b0;
        byte_cycle(1, 0);
        check("t3_en_drop", corrupt_en_o, 0);
        finish_frame();
        en = 1'b1;
        send_frame(1, em);
        check("t3_reenter", em, 1);
        mode = 2'd0;
        send_frame(1, em);
        check("t3_mode0", em, 0);

        // Burst/gap pattern.
        do_reset();
        set_cfg(1, 2'd2, 8'd2, 8'd3);
        for (int f = 0; f < 10; f++) begin
            send_frame(1, em);
            check("t4_pattern", em, pat4[f]);
        end
`ifdef CORRUPT_SCHED_STATS_EN
        check("t4_frames", frames_o, 4);
`endif

        // Single-shot, then re-arm by toggling enable.
        set_cfg(1, 2'd3, 8'd3, 8'd0);
        for (int f = 0; f < 5; f++) begin
            send_frame(1, em);
            check("t5_shot1", em, pat5[f]);
        end
        set_cfg(1, 2'd3, 8'd3, 8'd0);
        for (int f = 0; f < 4; f++) begin
            send_frame(1, em);
            check("t5_shot2", em, pat5[f]);
        end

        // Missing FAS during a burst, then asynchronous reset mid-frame.
        do_reset();
        set_cfg(1, 2'd2, 8'd5, 8'd1);
        for (int f = 0; f < 3; f++) send_frame(1, em);
        check("t6_en_before", corrupt_en_o, 1);
        byte_cycle(1, 0);
        check("t6_locked", locked_o, 0);
        check("t6_en", corrupt_en_o, 0);
`ifdef CORRUPT_SCHED_STATS_EN
        check("t6_losses", losses_o, 1);
`endif
        for (int i = 0; i < 7; i++) byte_cycle(1, 0);
        do_reset();

        // Random stream: occasional missing or misplaced FAS, enable toggles, config changes while disabled.
        en = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            bit v, f;
            if ($urandom_range(0, 149) == 0) en = ~en;
            if (!en && $urandom_range(0, 9) == 0) begin
                mode  = 2'($urandom_range(0, 3));
                burst = 8'($urandom_range(1, 4));
                gap   = 8'($urandom_range(0, 3));
            end
            v = ($urandom_range(0, 3) != 0);
            f = v && ((m_p == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 99) == 0));
            byte_cycle(v, f);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
